alu_issue_ctrl: RTL and testbench

Instruction-side initiator for the 32-bit combinational ALU: accepts one decoded-register instruction at a time, encodes its opcode/funct into the ALU's 6-bit operation code, builds the two operands, holds them stable while the ALU settles, and captures result and zero flag into a response register. It sits between the register-read stage and writeback/branch logic of the processor datapath and is the only block that drives the ALU's operand and operation inputs.

---
 rtl/alu_issue_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit combinational ALU: decodes one instruction, drives and holds
// the ALU operands for SETTLE_CYCLES, then captures the result into a response register.
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] INSTR,
  input  logic [31:0] RS_DATA,
  input  logic [31:0] RT_DATA,
  output logic [31:0] ALU_OP1,
  output logic [31:0] ALU_OP2,
  output logic [5:0]  ALU_OPRN,
  input  logic [31:0] ALU_OUT,
  input  logic        ALU_ZERO,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RESULT,
  output logic        RSP_ZERO,
  output logic        RSP_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } state_t;

  localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm;
  logic [31:0] w_simm;
  logic [31:0] w_zimm;

  logic        w_dec_ok;
  logic [5:0]  w_dec_oprn;
  logic [31:0] w_dec_op1;
  logic [31:0] w_dec_op2;

  // Register indexes arrive already resolved as RS_DATA/RT_DATA.
  logic        w_unused_fields;

  assign w_opcode        = INSTR[31:26];
  assign w_funct         = INSTR[5:0];
  assign w_shamt         = INSTR[10:6];
  assign w_imm           = INSTR[15:0];
  assign w_simm          = {{16{w_imm[15]}}, w_imm};
  assign w_zimm          = {16'h0000, w_imm};
  assign w_unused_fields = ^INSTR[25:16];

  // Instruction decode into ALU operation code and operands.
  always_comb begin
    w_dec_ok   = 1'b1;
    w_dec_oprn = '0;
    w_dec_op1  = RS_DATA;
    w_dec_op2  = RT_DATA;
    case (w_opcode)
      6'h00: begin
        case (w_funct)
          6'h20: w_dec_oprn = 6'h01;
          6'h22: w_dec_oprn = 6'h02;
          6'h2C: w_dec_oprn = 6'h03;
          6'h02: begin
            w_dec_oprn = 6'h04;
            w_dec_op2  = {27'b0, w_shamt};
          end
          6'h01: begin
            w_dec_oprn = 6'h05;
            w_dec_op2  = {27'b0, w_shamt};
          end
          6'h24: w_dec_oprn = 6'h06;
          6'h25: w_dec_oprn = 6'h07;
          6'h27: w_dec_oprn = 6'h08;
          6'h2A: w_dec_oprn = 6'h09;
          default: w_dec_ok = 1'b0;
        endcase
      end
      6'h08: begin
        w_dec_oprn = 6'h01;
        w_dec_op2  = w_simm;
      end
      6'h1D: begin
        w_dec_oprn = 6'h03;
        w_dec_op2  = w_simm;
      end
      6'h0C: begin
        w_dec_oprn = 6'h06;
        w_dec_op2  = w_zimm;
      end
      6'h0D: begin
        w_dec_oprn = 6'h07;
        w_dec_op2  = w_zimm;
      end
      6'h0A: begin
        w_dec_oprn = 6'h09;
        w_dec_op2  = w_simm;
      end
      6'h0F: begin
        w_dec_oprn = 6'h05;
        w_dec_op1  = w_zimm;
        w_dec_op2  = 32'd16;
      end
      6'h04, 6'h05: begin
        w_dec_oprn = 6'h02;
        w_dec_op2  = RT_DATA;
      end
      default: w_dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (REQ_VALID) w_state_nxt = w_dec_ok ? ST_ISSUE : ST_RESP;
      end
      ST_ISSUE: begin
        if (r_cnt == '0) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (RSP_READY) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    REQ_READY = (r_state == ST_IDLE) && !RST;
    RSP_VALID = (r_state == ST_RESP);
  end

  // Operands hold across the return to IDLE; only the operation code is cleared.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt      <= '0;
      ALU_OP1    <= '0;
      ALU_OP2    <= '0;
      ALU_OPRN   <= '0;
      RSP_RESULT <= '0;
      RSP_ZERO   <= 1'b0;
      RSP_ERR    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            if (w_dec_ok) begin
              ALU_OPRN <= w_dec_oprn;
              ALU_OP1  <= w_dec_op1;
              ALU_OP2  <= w_dec_op2;
              r_cnt    <= LP_SETTLE_LOAD;
            end else begin
              RSP_RESULT <= '0;
              RSP_ZERO   <= 1'b0;
              RSP_ERR    <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (r_cnt == '0) begin
            RSP_RESULT <= ALU_OUT;
            RSP_ZERO   <= ALU_ZERO;
            RSP_ERR    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (RSP_READY) ALU_OPRN <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one instance with the default settle time, one with 3.
module tb_alu_issue_ctrl;

  logic        CLK;
  logic        RST;

  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_zero, a_rsp_err, a_alu_zero;
  logic [31:0] a_instr, a_rs, a_rt, a_op1, a_op2, a_alu_out, a_rsp_result;
  logic [5:0]  a_oprn;

  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_zero, b_rsp_err, b_alu_zero;
  logic [31:0] b_instr, b_rs, b_rt, b_op1, b_op2, b_alu_out, b_rsp_result;
  logic [5:0]  b_oprn;

  int unsigned total;
  int unsigned bad;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [5:0]  oprn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  alu_issue_ctrl dut_a (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(a_req_valid), .REQ_READY(a_req_ready),
    .INSTR(a_instr), .RS_DATA(a_rs), .RT_DATA(a_rt),
    .ALU_OP1(a_op1), .ALU_OP2(a_op2), .ALU_OPRN(a_oprn),
    .ALU_OUT(a_alu_out), .ALU_ZERO(a_alu_zero),
    .RSP_VALID(a_rsp_valid), .RSP_READY(a_rsp_ready),
    .RSP_RESULT(a_rsp_result), .RSP_ZERO(a_rsp_zero), .RSP_ERR(a_rsp_err)
  );

  alu_issue_ctrl #(.SETTLE_CYCLES(3)) dut_b (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready),
    .INSTR(b_instr), .RS_DATA(b_rs), .RT_DATA(b_rt),
    .ALU_OP1(b_op1), .ALU_OP2(b_op2), .ALU_OPRN(b_oprn),
    .ALU_OUT(b_alu_out), .ALU_ZERO(b_alu_zero),
    .RSP_VALID(b_rsp_valid), .RSP_READY(b_rsp_ready),
    .RSP_RESULT(b_rsp_result), .RSP_ZERO(b_rsp_zero), .RSP_ERR(b_rsp_err)
  );

  function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      6'h01:   return x + y;
      6'h02:   return x - y;
      6'h03:   return x * y;
      6'h04:   return x >> y[4:0];
      6'h05:   return x << y[4:0];
      6'h06:   return x & y;
      6'h07:   return x | y;
      6'h08:   return ~(x | y);
      6'h09:   return {31'b0, ($signed(x) < $signed(y))};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rtype(input logic [5:0] f, input logic [4:0] sh);
    return {6'h00, 5'd1, 5'd2, 5'd3, sh, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  assign a_alu_out  = alu_f(a_oprn, a_op1, a_op2);
  assign a_alu_zero = (a_alu_out == 32'h0);
  assign b_alu_out  = alu_f(b_oprn, b_op1, b_op2);
  assign b_alu_zero = (b_alu_out == 32'h0);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    total++; if (a_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_during: got %b want 0", a_req_ready); end
    RST = 1'b0;
    #1;
    total++; if (a_req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", a_req_ready); end
    total++; if (a_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", a_rsp_valid); end
    total++; if (a_oprn !== 6'h00) begin bad++; $display("FAIL rst_oprn: got %h want 00", a_oprn); end
    total++; if ({a_op1, a_op2} !== 64'h0) begin bad++; $display("FAIL rst_ops: got %h want 0", {a_op1, a_op2}); end
    total++; if ({a_rsp_result, a_rsp_zero, a_rsp_err} !== 34'h0) begin bad++; $display("FAIL rst_rsp: got %h want 0", {a_rsp_result, a_rsp_zero, a_rsp_err}); end
  endtask

  task automatic test_alu_ops;
    vec_t tbl[12];
    tbl[0]  = '{rtype(6'h20, 5'd0), 32'h7,        32'h5,  6'h01, 32'h7,        32'h5,        32'hC,        1'b0};
    tbl[1]  = '{rtype(6'h22, 5'd0), 32'h5,        32'h5,  6'h02, 32'h5,        32'h5,        32'h0,        1'b1};
    tbl[2]  = '{rtype(6'h2C, 5'd0), 32'h3,        32'h4,  6'h03, 32'h3,        32'h4,        32'hC,        1'b0};
    tbl[3]  = '{rtype(6'h02, 5'd4), 32'h80000000, 32'h99, 6'h04, 32'h80000000, 32'h4,        32'h08000000, 1'b0};
    tbl[4]  = '{rtype(6'h27, 5'd0), 32'h0,        32'h0,  6'h08, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0};
    tbl[5]  = '{rtype(6'h2A, 5'd0), 32'hFFFFFFFF, 32'h1,  6'h09, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0};
    tbl[6]  = '{itype(6'h04, 16'h0),    32'h1234,     32'h1234, 6'h02, 32'h1234,     32'h1234,     32'h0,        1'b1};
    tbl[7]  = '{itype(6'h0F, 16'hABCD), 32'h5555,     32'h0,    6'h05, 32'hABCD,     32'd16,       32'hABCD0000, 1'b0};
    tbl[8]  = '{itype(6'h08, 16'hFFFF), 32'h10,       32'h0,    6'h01, 32'h10,       32'hFFFFFFFF, 32'hF,        1'b0};
    tbl[9]  = '{itype(6'h0C, 16'hFFFF), 32'hFFFF1234, 32'h0,    6'h06, 32'hFFFF1234, 32'h0000FFFF, 32'h1234,     1'b0};
    tbl[10] = '{itype(6'h0A, 16'hFFFF), 32'h0,        32'h0,    6'h09, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[11] = '{itype(6'h0D, 16'h8000), 32'h1,        32'h0,    6'h07, 32'h1,        32'h8000,     32'h8001,     1'b0};
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      a_req_valid = 1'b1; a_instr = tbl[i].instr; a_rs = tbl[i].rs; a_rt = tbl[i].rt;
      @(negedge CLK);
      a_req_valid = 1'b0;
      total++; if (a_oprn !== tbl[i].oprn) begin bad++; $display("FAIL op%0d_oprn: got %h want %h", i, a_oprn, tbl[i].oprn); end
      total++; if (a_op1 !== tbl[i].op1) begin bad++; $display("FAIL op%0d_op1: got %h want %h", i, a_op1, tbl[i].op1); end
      total++; if (a_op2 !== tbl[i].op2) begin bad++; $display("FAIL op%0d_op2: got %h want %h", i, a_op2, tbl[i].op2); end
      total++; if ({a_rsp_valid, a_req_ready} !== 2'b00) begin bad++; $display("FAIL op%0d_issue_hs: got %b want 00", i, {a_rsp_valid, a_req_ready}); end
      @(negedge CLK);
      total++; if (a_rsp_valid !== 1'b1) begin bad++; $display("FAIL op%0d_rsp_valid: got %b want 1", i, a_rsp_valid); end
      total++; if (a_rsp_result !== tbl[i].res) begin bad++; $display("FAIL op%0d_result: got %h want %h", i, a_rsp_result, tbl[i].res); end
      total++; if ({a_rsp_zero, a_rsp_err} !== {tbl[i].zero, 1'b0}) begin bad++; $display("FAIL op%0d_zero_err: got %b want %b", i, {a_rsp_zero, a_rsp_err}, {tbl[i].zero, 1'b0}); end
      a_rsp_ready = 1'b1;
      @(negedge CLK);
      a_rsp_ready = 1'b0;
      total++; if ({a_rsp_valid, a_req_ready} !== 2'b01) begin bad++; $display("FAIL op%0d_done_hs: got %b want 01", i, {a_rsp_valid, a_req_ready}); end
      total++; if (a_oprn !== 6'h00) begin bad++; $display("FAIL op%0d_oprn_clr: got %h want 00", i, a_oprn); end
      total++; if (a_op1 !== tbl[i].op1) begin bad++; $display("FAIL op%0d_op1_hold: got %h want %h", i, a_op1, tbl[i].op1); end
    end
  endtask

  task automatic test_error;
    logic [31:0] bad_instr[2];
    bad_instr[0] = itype(6'h23, 16'h0004);
    bad_instr[1] = rtype(6'h3F, 5'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      a_req_valid = 1'b1; a_instr = bad_instr[i]; a_rs = 32'hDEAD; a_rt = 32'hBEEF;
      @(negedge CLK);
      a_req_valid = 1'b0;
      total++; if ({a_rsp_valid, a_rsp_err, a_rsp_zero} !== 3'b110) begin bad++; $display("FAIL err%0d_flags: got %b want 110", i, {a_rsp_valid, a_rsp_err, a_rsp_zero}); end
      total++; if (a_rsp_result !== 32'h0) begin bad++; $display("FAIL err%0d_result: got %h want 0", i, a_rsp_result); end
      total++; if (a_oprn !== 6'h00) begin bad++; $display("FAIL err%0d_oprn: got %h want 00", i, a_oprn); end
      total++; if ({a_op1, a_op2} !== {32'h1, 32'h8000}) begin bad++; $display("FAIL err%0d_ops_hold: got %h want %h", i, {a_op1, a_op2}, {32'h1, 32'h8000}); end
      a_rsp_ready = 1'b1;
      @(negedge CLK);
      a_rsp_ready = 1'b0;
      total++; if ({a_rsp_valid, a_req_ready} !== 2'b01) begin bad++; $display("FAIL err%0d_done_hs: got %b want 01", i, {a_rsp_valid, a_req_ready}); end
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] rv_exp;
    logic [5:0] rr_exp;
    rv_exp = 6'b010010;
    rr_exp = 6'b100100;
    @(negedge CLK);
    a_rsp_ready = 1'b1; a_req_valid = 1'b1; a_instr = rtype(6'h20, 5'd0); a_rs = 32'h1; a_rt = 32'h2;
    @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      total++; if ({a_rsp_valid, a_req_ready} !== {rv_exp[i], rr_exp[i]}) begin bad++; $display("FAIL b2b%0d_hs: got %b want %b", i, {a_rsp_valid, a_req_ready}, {rv_exp[i], rr_exp[i]}); end
      if (rv_exp[i]) begin
        total++; if ({a_rsp_result, a_rsp_err} !== {32'h3, 1'b0}) begin bad++; $display("FAIL b2b%0d_rsp: got %h want %h", i, {a_rsp_result, a_rsp_err}, {32'h3, 1'b0}); end
      end
      if (i == 5) a_req_valid = 1'b0;
      @(negedge CLK);
    end
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    @(negedge CLK);
    b_rsp_ready = 1'b0; b_req_valid = 1'b1; b_instr = rtype(6'h20, 5'd0); b_rs = 32'h7; b_rt = 32'h5;
    @(negedge CLK);
    b_instr = rtype(6'h22, 5'd0); b_rs = 32'h9; b_rt = 32'h4;
    total++; if ({b_oprn, b_op1} !== {6'h01, 32'h7}) begin bad++; $display("FAIL bp_issue: got %h want %h", {b_oprn, b_op1}, {6'h01, 32'h7}); end
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      total++; if ({b_rsp_valid, b_oprn, b_op1, b_op2} !== {1'b0, 6'h01, 32'h7, 32'h5}) begin bad++; $display("FAIL bp_settle%0d: got %h want %h", k, {b_rsp_valid, b_oprn, b_op1, b_op2}, {1'b0, 6'h01, 32'h7, 32'h5}); end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      total++; if ({b_rsp_valid, b_req_ready} !== 2'b10) begin bad++; $display("FAIL bp_hold%0d_hs: got %b want 10", k, {b_rsp_valid, b_req_ready}); end
      total++; if ({b_rsp_result, b_rsp_zero, b_rsp_err} !== {32'hC, 2'b00}) begin bad++; $display("FAIL bp_hold%0d_rsp: got %h want %h", k, {b_rsp_result, b_rsp_zero, b_rsp_err}, {32'hC, 2'b00}); end
    end
    b_rsp_ready = 1'b1;
    @(negedge CLK);
    b_rsp_ready = 1'b0;
    total++; if ({b_rsp_valid, b_req_ready, b_oprn} !== {2'b01, 6'h00}) begin bad++; $display("FAIL bp_exit: got %h want %h", {b_rsp_valid, b_req_ready, b_oprn}, {2'b01, 6'h00}); end
    @(negedge CLK);
    b_req_valid = 1'b0;
    total++; if ({b_req_ready, b_oprn, b_op1, b_op2} !== {1'b0, 6'h02, 32'h9, 32'h4}) begin bad++; $display("FAIL bp_next_accept: got %h want %h", {b_req_ready, b_oprn, b_op1, b_op2}, {1'b0, 6'h02, 32'h9, 32'h4}); end
    repeat (2) @(negedge CLK);
    total++; if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_next_early: got %b want 0", b_rsp_valid); end
    @(negedge CLK);
    total++; if ({b_rsp_valid, b_rsp_result} !== {1'b1, 32'h5}) begin bad++; $display("FAIL bp_next_rsp: got %h want %h", {b_rsp_valid, b_rsp_result}, {1'b1, 32'h5}); end
    b_rsp_ready = 1'b1;
    @(negedge CLK);
    b_rsp_ready = 1'b0;
    total++; if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_next_done: got %b want 0", b_rsp_valid); end
  endtask

  task automatic test_reset_abort;
    @(negedge CLK);
    b_req_valid = 1'b1; b_instr = rtype(6'h20, 5'd0); b_rs = 32'h7; b_rt = 32'h5;
    @(negedge CLK);
    b_req_valid = 1'b0;
    total++; if (b_oprn !== 6'h01) begin bad++; $display("FAIL abort_issued: got %h want 01", b_oprn); end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    total++; if (b_req_ready !== 1'b0) begin bad++; $display("FAIL abort_ready_during: got %b want 0", b_req_ready); end
    RST = 1'b0;
    #1;
    total++; if ({b_req_ready, b_rsp_valid, b_oprn} !== {2'b10, 6'h00}) begin bad++; $display("FAIL abort_ctrl: got %h want %h", {b_req_ready, b_rsp_valid, b_oprn}, {2'b10, 6'h00}); end
    total++; if ({b_op1, b_op2} !== 64'h0) begin bad++; $display("FAIL abort_ops: got %h want 0", {b_op1, b_op2}); end
    total++; if ({b_rsp_result, b_rsp_zero, b_rsp_err} !== 34'h0) begin bad++; $display("FAIL abort_rsp: got %h want 0", {b_rsp_result, b_rsp_zero, b_rsp_err}); end
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      total++; if (b_rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_no_rsp%0d: got %b want 0", k, b_rsp_valid); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST = 1'b1;
    a_req_valid = 1'b0; a_rsp_ready = 1'b0; a_instr = '0; a_rs = '0; a_rt = '0;
    b_req_valid = 1'b0; b_rsp_ready = 1'b0; b_instr = '0; b_rs = '0; b_rt = '0;
    test_reset;
    test_alu_ops;
    test_error;
    test_back_to_back;
    test_backpressure;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
